// File: rtl/reg_reader_pkg.sv
// Shared types and sizing helpers for the register word reader.
package reg_reader_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Counter must hold the value WIDTH itself, hence WIDTH+1.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/shift_reg_ld.sv
// Loadable shift register; shifts toward the output end and fills with zero.
module shift_reg_ld #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             shift_en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (reset) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end else if (shift_en) begin
            q <= MSB_FIRST ? (q << 1) : (q >> 1);
        end
    end

endmodule

// File: rtl/reg_word_reader.sv
// Captures a register word on request and streams it out bit-serially.
// Handshake: a bit is transferred on every rising Clk edge where BitValid && Ready;
// BitValid and BitOut depend on registered state only and never on Ready.
module reg_word_reader
    import reg_reader_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [WIDTH-1:0] WordIn,
    input  logic             ReadReq,
    input  logic             Ready,
    output logic             BitOut,
    output logic             BitValid,
    output logic             Busy,
    output logic             Done,
    output state_t           state_dbg
);

    localparam int CW = cnt_width(WIDTH);

    state_t           state;
    state_t           state_nxt;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] shreg;
    logic             load;
    logic             shift_en;

    shift_reg_ld #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_shreg (
        .clk      (Clk),
        .reset    (Reset),
        .load     (load),
        .shift_en (shift_en),
        .d        (WordIn),
        .q        (shreg)
    );

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        shift_en  = 1'b0;
        case (state)
            IDLE: begin
                if (ReadReq) begin
                    load      = 1'b1;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (Ready) begin
                    shift_en = 1'b1;
                    if (cnt == CW'(1)) begin
                        state_nxt = DONE;
                    end
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            if (load) begin
                cnt <= CW'(WIDTH);
            end else if (shift_en) begin
                cnt <= cnt - CW'(1);
            end
        end
    end

    // BitOut is forced low outside SHIFT so idle/done cycles never show stale data.
    assign BitValid  = (state == SHIFT);
    assign BitOut    = BitValid & (MSB_FIRST ? shreg[WIDTH-1] : shreg[0]);
    assign Busy      = (state != IDLE);
    assign Done      = (state == DONE);
    assign state_dbg = state;

endmodule
